// File: rtl/rat_uart_tx_port_if.sv
// RAT MCU output bus: port address, data and strobe.
// The MCU drives the master side; peripherals listen on the slave side.
interface rat_uart_tx_port_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB
  );

  modport slave (
    input PORT_ID,
    input OUT_PORT,
    input IO_STRB
  );
endinterface

// File: rtl/rat_uart_tx_port.sv
// RAT MCU UART transmit peripheral: byte FIFO fed by OUT
// instructions, 8N1 serialiser, status byte and drain interrupt.
module rat_uart_tx_port #(
  parameter logic [7:0] TX_PORT_ID   = 8'h40,
  parameter logic [7:0] STAT_PORT_ID = 8'h41,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  rat_uart_tx_port_if.slave     i_bus,
  output logic [7:0]            STATUS,
  output logic                  TX,
  output logic                  TX_BUSY,
  output logic                  INTR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [3:0]    DEPTH  = 4'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [3:0]    r_count;
  logic          r_ovr;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_intr;

  logic       w_empty;
  logic       w_full;
  logic       w_wr;
  logic       w_ctl;
  logic       w_push;
  logic       w_pop;
  logic       w_flush;
  logic       w_clr;
  logic       w_tend;
  logic [7:0] w_head;

  assign w_empty = (r_count == 4'd0);
  assign w_full  = (r_count == DEPTH);
  assign w_wr    = i_bus.IO_STRB &&
                   (i_bus.PORT_ID == TX_PORT_ID);
  assign w_ctl   = i_bus.IO_STRB &&
                   (i_bus.PORT_ID == STAT_PORT_ID);
  assign w_push  = w_wr && !w_full;
  assign w_flush = w_ctl && i_bus.OUT_PORT[0];
  assign w_clr   = w_ctl && i_bus.OUT_PORT[1];
  assign w_tend  = (r_timer == T_LAST);
  assign w_head  = r_mem[r_rptr];

  // The serialiser takes the head in IDLE or at the last stop cycle.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) ||
                  ((r_state == STOP) && w_tend));

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= i_bus.OUT_PORT;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + 4'(w_push) - 4'(w_pop);
      end
      if (w_wr && w_full) r_ovr <= 1'b1;
      else if (w_clr)     r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_intr  <= 1'b0;
    end else begin
      r_intr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_tx    <= 1'b1;
          r_timer <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_tend) begin
            r_timer <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DATA: begin
          if (w_tend) begin
            r_timer <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        STOP: begin
          if (w_tend) begin
            r_timer <= '0;
            if (w_pop) begin
              // Next frame follows with no idle gap.
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_intr  <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TX      = r_tx;
  assign INTR    = r_intr;
  assign TX_BUSY = (r_state != IDLE);
  assign STATUS  = {r_count, r_ovr, w_empty, w_full, TX_BUSY};

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Directed bench for rat_uart_tx_port at 4 clocks per bit,
// 8-entry FIFO; inputs change and outputs are sampled on negedges.
module tb_rat_uart_tx_port;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] STATUS;
  logic       TX;
  logic       TX_BUSY;
  logic       INTR;

  int n_assert = 0;
  int n_fail   = 0;

  rat_uart_tx_port_if bus ();

  rat_uart_tx_port #(
    .TX_PORT_ID  (8'h40),
    .STAT_PORT_ID(8'h41),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (8)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .i_bus  (bus),
    .STATUS (STATUS),
    .TX     (TX),
    .TX_BUSY(TX_BUSY),
    .INTR   (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] id, input logic [7:0] d);
    @(negedge CLK);
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    bus.IO_STRB  = 1'b1;
  endtask

  task automatic release_bus();
    @(negedge CLK);
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
  endtask

  // first < 0: wait for the start bit; otherwise resume at that cycle.
  task automatic rx_frame(input logic [7:0] b, input int first);
    logic [9:0] f;
    int n;
    int s;
    f = {1'b1, b, 1'b0};
    s = first;
    if (s < 0) begin
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (TX !== 1'b0 && n < 60);
      check($sformatf("start_seen_%02h", b), {31'd0, TX}, 32'd0);
      check($sformatf("frame_%02h_c0", b), {30'd0, INTR, TX},
            {30'd0, 1'b0, f[0]});
      s = 1;
    end
    for (int i = s; i < 40; i++) begin
      @(negedge CLK);
      check($sformatf("frame_%02h_c%0d", b, i), {30'd0, INTR, TX},
            {30'd0, 1'b0, f[i/4]});
    end
  endtask

  task automatic idle_chk(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge CLK);
      if (TX !== 1'b1 || INTR !== 1'b0 || TX_BUSY !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic intr_end(input string tag);
    @(negedge CLK);
    check({tag, "_intr"}, {31'd0, INTR}, 32'd1);
    check({tag, "_busy"}, {31'd0, TX_BUSY}, 32'd0);
    @(negedge CLK);
    check({tag, "_intr_low"}, {31'd0, INTR}, 32'd0);
  endtask

  initial begin
    RESET_N      = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // 1: reset state and a single frame
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_status", {24'd0, STATUS}, 32'h04);
    check("rst_intr", {31'd0, INTR}, 32'd0);
    drive(8'h40, 8'hA5);
    release_bus();
    check("c1_status_push", {24'd0, STATUS}, 32'h10);
    rx_frame(8'hA5, -1);
    intr_end("c1");
    check("c1_status", {24'd0, STATUS}, 32'h04);

    // 2: overfill, back-to-back frames
    for (int i = 0; i < 10; i++) drive(8'h40, 8'(i));
    release_bus();
    check("c2_status_full", {24'd0, STATUS}, 32'h8B);
    rx_frame(8'h00, 9);
    for (int k = 1; k <= 8; k++) rx_frame(8'(k), 0);
    intr_end("c2");
    check("c2_status_end", {24'd0, STATUS}, 32'h0C);

    // 3: clear overrun
    drive(8'h41, 8'h02);
    release_bus();
    check("c3_status", {24'd0, STATUS}, 32'h04);

    // 4: flush mid-frame
    drive(8'h40, 8'h11);
    drive(8'h40, 8'h22);
    drive(8'h40, 8'h33);
    drive(8'h41, 8'h01);
    release_bus();
    check("c4_status_flush", {24'd0, STATUS}, 32'h05);
    rx_frame(8'h11, 3);
    intr_end("c4");
    check("c4_status", {24'd0, STATUS}, 32'h04);
    idle_chk("c4_no_more_frames", 50);

    // 5: async reset during DATA
    drive(8'h40, 8'h3C);
    release_bus();
    repeat (6) @(negedge CLK);
    check("c5_busy", {31'd0, TX_BUSY}, 32'd1);
    check("c5_tx_data", {31'd0, TX}, 32'd0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("c5_rst_tx", {31'd0, TX}, 32'd1);
    check("c5_rst_status", {24'd0, STATUS}, 32'h04);
    check("c5_rst_intr", {31'd0, INTR}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    idle_chk("c5_after_rst", 12);
    drive(8'h40, 8'hC3);
    release_bus();
    rx_frame(8'hC3, -1);
    intr_end("c5");

    // 6: foreign port ignored
    drive(8'h42, 8'hFF);
    release_bus();
    check("c6_status", {24'd0, STATUS}, 32'h04);
    idle_chk("c6_no_tx", 30);
    check("c6_status_end", {24'd0, STATUS}, 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
